// File: rtl/isa_pkg.sv
// ISA constants, field positions and the decoded bundle
// shared between the decode and execute stages.
package isa_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_ANDI = 4'h5;
  localparam logic [3:0] OP_ORI  = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_LW   = 4'h8;
  localparam logic [3:0] OP_SW   = 4'h9;
  localparam logic [3:0] OP_BEQ  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_NOP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int INSTR_W = 16;
  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 9;
  localparam int RS1_LSB = 6;
  localparam int RS2_LSB = 3;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_FULL  = 2'd1,
    OCC_SKID  = 2'd2
  } occ_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;
    logic [7:0] imm8;
    logic       sext;
    logic       uses_imm;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       halt;
    logic       illegal;
  } dec_t;

  localparam int DEC_W = $bits(dec_t);

endpackage

// File: rtl/instr_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle
// of the decode stage.
interface instr_decode_stage_if #(
  parameter int PC_WIDTH = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [15:0]         in_instr;
  logic [PC_WIDTH-1:0] in_pc;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] out_pc;
  logic [3:0]          out_opcode;
  logic [2:0]          out_rd;
  logic [2:0]          out_rs1;
  logic [2:0]          out_rs2;
  logic [7:0]          out_imm8;
  logic                out_sign_extend_en;
  logic                out_uses_imm;
  logic                out_reg_write;
  logic                out_mem_read;
  logic                out_mem_write;
  logic                out_branch;
  logic                out_halt;
  logic                out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc,
    output out_opcode, out_rd, out_rs1, out_rs2,
    output out_imm8, out_sign_extend_en,
    output out_uses_imm, out_reg_write,
    output out_mem_read, out_mem_write,
    output out_branch, out_halt, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc,
    input  out_opcode, out_rd, out_rs1, out_rs2,
    input  out_imm8, out_sign_extend_en,
    input  out_uses_imm, out_reg_write,
    input  out_mem_read, out_mem_write,
    input  out_branch, out_halt, out_illegal
  );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational split of an instruction word into
// fields and control flags.
module instr_field_decode
  import isa_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_t               dec
);

  // field slices plus opcode -> control flag table
  always_comb begin
    dec        = '0;
    dec.opcode = instr[OPC_LSB +: 4];
    dec.rd     = instr[RD_LSB +: 3];
    dec.rs1    = instr[RS1_LSB +: 3];
    dec.rs2    = instr[RS2_LSB +: 3];
    dec.imm8   = instr[IMM_LSB +: 8];
    unique case (dec.opcode)
      OP_ADD, OP_SUB, OP_AND, OP_OR: begin
        dec.reg_write = 1'b1;
      end
      OP_ADDI: begin
        dec.sext      = 1'b1;
        dec.uses_imm  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_LI: begin
        dec.uses_imm  = 1'b1;
        dec.reg_write = 1'b1;
      end
      OP_LW: begin
        dec.sext      = 1'b1;
        dec.uses_imm  = 1'b1;
        dec.reg_write = 1'b1;
        dec.mem_read  = 1'b1;
      end
      OP_SW: begin
        dec.sext      = 1'b1;
        dec.uses_imm  = 1'b1;
        dec.mem_write = 1'b1;
      end
      OP_BEQ, OP_JMP: begin
        dec.sext     = 1'b1;
        dec.uses_imm = 1'b1;
        dec.branch   = 1'b1;
      end
      OP_NOP: begin
      end
      OP_HALT: begin
        dec.halt = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Registered decode stage with a 2-entry skid buffer,
// flush and a sticky halt.
module instr_decode_stage
  import isa_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  instr_decode_stage_if.slave   bus
);

  dec_t                in_dec;
  occ_e                state_q, state_d;
  logic                halted_q, halted_d;
  logic                in_ready_q, in_ready_d;
  dec_t                out_q, out_d;
  dec_t                skid_q, skid_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                in_fire;
  logic                out_fire;
  logic                out_valid;

  instr_field_decode u_dec (
    .instr (bus.in_instr),
    .dec   (in_dec)
  );

  assign out_valid = (state_q != OCC_EMPTY);
  assign in_fire   = bus.in_valid & in_ready_q;
  assign out_fire  = out_valid & bus.out_ready;

  // next occupancy, register contents and ready
  always_comb begin
    state_d   = state_q;
    halted_d  = halted_q;
    out_d     = out_q;
    out_pc_d  = out_pc_q;
    skid_d    = skid_q;
    skid_pc_d = skid_pc_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      if (in_fire && in_dec.halt) begin
        halted_d = 1'b1;
      end
      unique case (state_q)
        OCC_EMPTY: begin
          if (in_fire) begin
            out_d    = in_dec;
            out_pc_d = bus.in_pc;
            state_d  = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (in_fire && out_fire) begin
            out_d    = in_dec;
            out_pc_d = bus.in_pc;
          end else if (out_fire) begin
            state_d = OCC_EMPTY;
          end else if (in_fire) begin
            skid_d    = in_dec;
            skid_pc_d = bus.in_pc;
            state_d   = OCC_SKID;
          end
        end
        OCC_SKID: begin
          if (out_fire) begin
            out_d    = skid_q;
            out_pc_d = skid_pc_q;
            state_d  = OCC_FULL;
          end
        end
        default: begin
          state_d = OCC_EMPTY;
        end
      endcase
    end
    in_ready_d = (state_d != OCC_SKID) & ~halted_d;
  end

  // state and data registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= OCC_EMPTY;
      halted_q   <= 1'b0;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      out_pc_q   <= '0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      state_q    <= state_d;
      halted_q   <= halted_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      out_pc_q   <= out_pc_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
    end
  end

  assign bus.in_ready           = in_ready_q;
  assign bus.out_valid          = out_valid;
  assign bus.out_pc             = out_pc_q;
  assign bus.out_opcode         = out_q.opcode;
  assign bus.out_rd             = out_q.rd;
  assign bus.out_rs1            = out_q.rs1;
  assign bus.out_rs2            = out_q.rs2;
  assign bus.out_imm8           = out_q.imm8;
  assign bus.out_sign_extend_en = out_q.sext;
  assign bus.out_uses_imm       = out_q.uses_imm;
  assign bus.out_reg_write      = out_q.reg_write;
  assign bus.out_mem_read       = out_q.mem_read;
  assign bus.out_mem_write      = out_q.mem_write;
  assign bus.out_branch         = out_q.branch;
  assign bus.out_halt           = out_q.halt;
  assign bus.out_illegal        = out_q.illegal;

endmodule

// File: doc/instr_decode_stage.md
Name: instr_decode_stage

Overview:
- Registered decode stage directly upstream of sign_extend_immediate. Accepts 16-bit instruction words from fetch over a valid/ready handshake and splits them into fields.
- Produces the 8-bit immediate and the sign_extend_en control that the extender consumes, plus register addresses and control flags for the execute stage.
- Contains a 2-entry skid buffer so that in_ready is driven only from a register, with a flush input and a sticky HALT state.

Parameters:
- PC_WIDTH, 8, width of the program counter carried alongside each instruction.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  fetch presents an instruction.
- in_ready  output  1  stage can accept; registered.
- in_instr  input  16  instruction word.
- in_pc  input  PC_WIDTH  PC of in_instr.
- flush  input  1  discard all held instructions (branch redirect).
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  downstream accepts the bundle.
- out_pc  output  PC_WIDTH  PC of the bundle.
- out_opcode  output  4  instr[15:12].
- out_rd  output  3  instr[11:9].
- out_rs1  output  3  instr[8:6].
- out_rs2  output  3  instr[5:3].
- out_imm8  output  8  instr[7:0]; feeds sign_extend_immediate.in.
- out_sign_extend_en  output  1  feeds sign_extend_immediate.sign_extend_en.
- out_uses_imm  output  1  ALU operand B selects the immediate.
- out_reg_write  output  1  writes rd.
- out_mem_read  output  1  load.
- out_mem_write  output  1  store.
- out_branch  output  1  BEQ or JMP.
- out_halt  output  1  HALT instruction.
- out_illegal  output  1  undefined opcode.

Behaviour:
- Opcode map and decode outputs (listed as sext, uses_imm, reg_write, mem_read, mem_write, branch):
  - 0 ADD, 1 SUB, 2 AND, 3 OR: 0,0,1,0,0,0.
  - 4 ADDI: 1,1,1,0,0,0.
  - 5 ANDI, 6 ORI, 7 LI: 0,1,1,0,0,0.
  - 8 LW: 1,1,1,1,0,0.
  - 9 SW: 1,1,0,0,1,0.
  - A BEQ, B JMP: 1,1,0,0,0,1.
  - E NOP: all 0.
  - F HALT: all 0, out_halt=1.
  - C, D: all 0, out_illegal=1.
- Decode is combinational on in_instr. Results are registered on acceptance, so there is 1 cycle of latency from in fire to out_valid.
- in fire = in_valid & in_ready; out fire = out_valid & out_ready.
- Occupancy FSM:
  - States are EMPTY, FULL (output register valid) and SKID (output register and skid register both valid).
  - EMPTY: in fire -> FULL.
  - FULL:
    - out fire, no in fire -> EMPTY.
    - out fire and in fire -> FULL, holding the new bundle.
    - in fire, no out fire -> SKID, with the new bundle in the skid register.
  - SKID: out fire -> FULL; the skid bundle moves to the output register on the same edge.
- in_ready = (state != SKID) & !halted. It is a registered next-state decode with no combinational path from out_ready.
- Outputs hold stable while out_valid=1 and out_ready=0.
- halted flag:
  - Set on the edge where a HALT instruction is accepted.
  - Once set, in_ready=0 until reset.
  - The HALT bundle itself is still delivered downstream. Instructions already in the skid register drain normally.
- flush:
  - Highest priority: state goes to EMPTY on the next edge and the skid register is invalidated.
  - An instruction offered in the same cycle is dropped, even if in_ready=1.
  - flush does not clear halted.
- Reset (asynchronous):
  - State EMPTY, halted=0, in_ready=1.
  - All out_* = 0, including out_valid.
  - Reset asserted mid-transfer discards everything in flight.
- No wrap or arithmetic in this block. Fields are pure bit slices; out_imm8 is passed unmodified.

Decomposition:
- Package isa_pkg: opcode localparams (OP_ADD..OP_HALT), field bit positions, occupancy state encoding, and a decoded-bundle struct/width constant that is shared with the execute stage.
- Sub-module instr_field_decode: combinational opcode -> control flags, instantiated once on in_instr.
- The stage itself holds only the FSM, the output register and the skid register.

Test Plan:
- ADDI: in_instr=0x4A85, out_ready=1 -> next cycle out_valid=1, rd=5, imm8=0x85, sign_extend_en=1, uses_imm=1, reg_write=1. The extender output is 0xFF85.
- ORI: in_instr=0x62F0 -> sign_extend_en=0, imm8=0xF0. The extender output is 0x00F0.
- Backpressure: stream 3 instructions with out_ready=0 -> in_ready drops after 2 accepted, the third is held by fetch. Raising out_ready delivers all 3 in order with no loss or duplication.
- Flush: hold out_ready=0 with 2 instructions in the stage, assert flush with in_valid=1 -> next cycle out_valid=0 and state EMPTY; the concurrent instruction never appears.
- HALT: send 0xF000 followed by ADD 0x0000 -> the HALT bundle is delivered with out_halt=1, in_ready stays 0 afterwards, and the ADD is never accepted. Asserting rst restores in_ready=1.
- Illegal and reset: 0xC123 -> out_illegal=1 with all other flags 0. Asserting rst between clock edges clears out_valid immediately, with no clock edge needed.
